// File: rtl/vga_timing_pkg.sv
// Default VGA 640x480@60 raster constants and the shared coordinate type.
// Optional feature macro used by the top: VGA_FRAME_CNT_EN.
package vga_timing_pkg;

  localparam int COORD_W   = 10;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus sync/visible flags decoded
// from the next count, so the caller can register them in step with the count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   enable_i,
  output coord_t count_o,
  output coord_t count_next_o,
  output logic   wrap_o,
  output logic   sync_n_o,
  output logic   visible_o
);

  localparam int     TOTAL      = VISIBLE + FRONT + SYNC + BACK;
  localparam coord_t LAST       = coord_t'(TOTAL - 1);
  localparam coord_t SYNC_START = coord_t'(VISIBLE + FRONT);
  localparam coord_t SYNC_END   = coord_t'(VISIBLE + FRONT + SYNC);
  localparam coord_t VIS_END    = coord_t'(VISIBLE);

  coord_t count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (enable_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + coord_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign wrap_o       = enable_i && (count_q == LAST);
  assign sync_n_o     = !((count_d >= SYNC_START) && (count_d < SYNC_END));
  assign visible_o    = (count_d < VIS_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: hs/vs/blank/vblank_start registered in step with
// DrawX/DrawY. Define VGA_FRAME_CNT_EN to add the frame_count output.
module vga_timing_gen
  import vga_timing_pkg::coord_t;
#(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
`ifdef VGA_FRAME_CNT_EN
  , parameter int FRAME_CNT_W = 8
`endif
) (
  input  logic   vga_clk,
  input  logic   reset_n,
  output logic   hs,
  output logic   vs,
  output logic   blank,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   vblank_start
`ifdef VGA_FRAME_CNT_EN
  , output logic [FRAME_CNT_W-1:0] frame_count
`endif
);

  coord_t hc, vc, vc_next, hc_next_unused;
  logic   h_wrap, v_wrap_unused;
  logic   hs_d, vs_d, h_vis, v_vis, vbs_d;
  logic   hs_q, vs_q, blank_q, vbs_q;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h_axis (
    .clk_i(vga_clk), .rst_ni(reset_n), .enable_i(1'b1),
    .count_o(hc), .count_next_o(hc_next_unused), .wrap_o(h_wrap),
    .sync_n_o(hs_d), .visible_o(h_vis)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v_axis (
    .clk_i(vga_clk), .rst_ni(reset_n), .enable_i(h_wrap),
    .count_o(vc), .count_next_o(vc_next), .wrap_o(v_wrap_unused),
    .sync_n_o(vs_d), .visible_o(v_vis)
  );

  // Next position is (0, V_VISIBLE) exactly when the line wraps into that row.
  assign vbs_d = h_wrap && (vc_next == coord_t'(V_VISIBLE));

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      vbs_q   <= 1'b0;
    end else begin
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= h_vis && v_vis;
      vbs_q   <= vbs_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n)   frame_q <= '0;
    else if (vbs_d) frame_q <= frame_q + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
  end

  assign frame_count = frame_q;
`endif

  assign hs           = hs_q;
  assign vs           = vs_q;
  assign blank        = blank_q;
  assign vblank_start = vbs_q;
  assign DrawX        = hc;
  assign DrawY        = vc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-raster instance for whole-frame behaviour and
// a default 640x480 instance for line timing. Define VGA_FRAME_CNT_EN to cover frame_count.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 2, SHT = 15;
  localparam int SVV = 6, SVF = 1, SVS = 2, SVB = 2, SVT = 11;
  localparam int SFT = SHT * SVT;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  logic   s_hs, s_vs, s_blank, s_vbs, d_hs, d_vs, d_blank, d_vbs;
  coord_t s_x, s_y, d_x, d_y;
`ifdef VGA_FRAME_CNT_EN
  logic [1:0] s_fc;
  logic [7:0] d_fc;
`endif

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
`ifdef VGA_FRAME_CNT_EN
    , .FRAME_CNT_W(2)
`endif
  ) dut_s (
    .vga_clk(clk), .reset_n(rst_n), .hs(s_hs), .vs(s_vs), .blank(s_blank),
    .DrawX(s_x), .DrawY(s_y), .vblank_start(s_vbs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_count(s_fc)
`endif
  );

  vga_timing_gen dut_d (
    .vga_clk(clk), .reset_n(rst_n), .hs(d_hs), .vs(d_vs), .blank(d_blank),
    .DrawX(d_x), .DrawY(d_y), .vblank_start(d_vbs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_count(d_fc)
`endif
  );

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  int edges = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    edges++;
    @(negedge clk);
  endtask

  // Expected {hs,vs,blank,vbs,x,y} for n edges after reset release (n >= 1).
  function automatic logic [23:0] exp_pack(input int n, input int hv, input int hf,
      input int hsy, input int hb, input int vv, input int vf, input int vsy, input int vb);
    int   ht, vt, hc, vc;
    logic e_hs, e_vs, e_bl, e_vb;
    ht   = hv + hf + hsy + hb;
    vt   = vv + vf + vsy + vb;
    hc   = n % ht;
    vc   = (n / ht) % vt;
    e_hs = !((hc >= hv + hf) && (hc < hv + hf + hsy));
    e_vs = !((vc >= vv + vf) && (vc < vv + vf + vsy));
    e_bl = (hc < hv) && (vc < vv);
    e_vb = (hc == 0) && (vc == vv);
    return {e_hs, e_vs, e_bl, e_vb, 10'(hc), 10'(vc)};
  endfunction

  function automatic logic [23:0] s_pack();
    return {s_hs, s_vs, s_blank, s_vbs, s_x, s_y};
  endfunction

  function automatic logic [23:0] d_pack();
    return {d_hs, d_vs, d_blank, d_vbs, d_x, d_y};
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_state"}, 32'(s_pack()), 32'({4'b1100, 20'd0}));
    check({tag, "_d_state"}, 32'(d_pack()), 32'({4'b1100, 20'd0}));
`ifdef VGA_FRAME_CNT_EN
    check({tag, "_s_fc"}, 32'(s_fc), 32'd0);
    check({tag, "_d_fc"}, 32'(d_fc), 32'd0);
`endif
  endtask

  typedef struct {
    bit dflt;
    int n;
    int x;
    int y;
    bit hs;
    bit vs;
    bit blank;
    bit vbs;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit dflt, input int n, input int x, input int y,
                     input bit h, input bit v, input bit b, input bit p);
    vec_t t;
    t.dflt = dflt; t.n = n; t.x = x; t.y = y;
    t.hs = h; t.vs = v; t.blank = b; t.vbs = p;
    vecs.push_back(t);
  endtask

  initial begin
    int model_bad, hs_low, vs_low, bl_high, pulses, off_pulse, gap_bad, last_pulse;
    int wait_n, hs_first, hs_last;
    logic [23:0] expv, act;

    // small raster: 15 clocks/line, 11 lines/frame, hs low 10..12, vs low rows 7..8
    add(0,   1,  1,  0, 1, 1, 1, 0);
    add(0,   7,  7,  0, 1, 1, 1, 0);
    add(0,   8,  8,  0, 1, 1, 0, 0);
    add(0,   9,  9,  0, 1, 1, 0, 0);
    add(0,  10, 10,  0, 0, 1, 0, 0);
    add(0,  12, 12,  0, 0, 1, 0, 0);
    add(0,  13, 13,  0, 1, 1, 0, 0);
    add(0,  15,  0,  1, 1, 1, 1, 0);
    add(0,  89, 14,  5, 1, 1, 0, 0);
    add(0,  90,  0,  6, 1, 1, 0, 1);
    add(0,  91,  1,  6, 1, 1, 0, 0);
    add(0, 105,  0,  7, 1, 0, 0, 0);
    add(0, 134, 14,  8, 1, 0, 0, 0);
    add(0, 135,  0,  9, 1, 1, 0, 0);
    add(0, 160, 10, 10, 0, 1, 0, 0);
    add(0, 164, 14, 10, 1, 1, 0, 0);
    add(0, 165,  0,  0, 1, 1, 1, 0);
    add(0, 255,  0,  6, 1, 1, 0, 1);
    // default 640x480 raster, first line
    add(1, 639, 639, 0, 1, 1, 1, 0);
    add(1, 640, 640, 0, 1, 1, 0, 0);
    add(1, 655, 655, 0, 1, 1, 0, 0);
    add(1, 656, 656, 0, 0, 1, 0, 0);
    add(1, 751, 751, 0, 0, 1, 0, 0);
    add(1, 752, 752, 0, 1, 1, 0, 0);
    add(1, 799, 799, 0, 1, 1, 0, 0);
    add(1, 800,   0, 1, 1, 1, 1, 0);

    // reset held
    repeat (3) @(negedge clk);
    check_reset_vals("in_reset");
    rst_n = 1'b1;
    edges = 0;

    foreach (vecs[i]) begin
      while (edges < vecs[i].n) step();
      act  = vecs[i].dflt ? d_pack() : s_pack();
      expv = {vecs[i].hs, vecs[i].vs, vecs[i].blank, vecs[i].vbs,
              10'(vecs[i].x), 10'(vecs[i].y)};
      check($sformatf("vec%0d_n%0d_%s", i, vecs[i].n, vecs[i].dflt ? "dflt" : "small"),
            32'(act), 32'(expv));
    end

    // default raster second line: hsync width and edges, plus both rasters vs model
    model_bad = 0; hs_low = 0; hs_first = -1; hs_last = -1;
    while (edges < 1600) begin
      step();
      if (d_pack() !== exp_pack(edges, 640, 16, 96, 48, 480, 10, 2, 33)) model_bad++;
      if (s_pack() !== exp_pack(edges, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB)) model_bad++;
      if (edges >= 800 && !d_hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(d_x);
        hs_last = int'(d_x);
      end
    end
    check("line1_hs_low_clocks", 32'(hs_low), 32'd96);
    check("line1_hs_first_x", 32'(hs_first), 32'd656);
    check("line1_hs_last_x", 32'(hs_last), 32'd751);
    check("line_end_pos", 32'(d_pack()), 32'({4'b1110, 10'd0, 10'd2}));
    check("model_scan_a", 32'(model_bad), 32'd0);

    // mid-frame asynchronous reset, well away from any clock edge
    #5 rst_n = 1'b0;
    #1 check_reset_vals("async_reset");
    step();
    check_reset_vals("reset_held");
    rst_n = 1'b1;
    edges = 0;
    step();
    check("restart_pos", 32'(s_pack()), 32'({4'b1110, 10'd1, 10'd0}));
    wait_n = 0;
    while (!s_vbs && wait_n < 200) begin
      step();
      wait_n++;
    end
    check("restart_to_vblank", 32'(wait_n), 32'((SVV - 1) * SHT + SHT - 1));
    check("first_vblank_pos", 32'({s_x, s_y}), 32'({10'd0, 10'(SVV)}));
`ifdef VGA_FRAME_CNT_EN
    check("fc_first_pulse", 32'(s_fc), 32'd1);
`endif

    // four whole small frames after the first pulse
    model_bad = 0; hs_low = 0; vs_low = 0; bl_high = 0; pulses = 0;
    off_pulse = 0; gap_bad = 0; last_pulse = edges;
    repeat (4 * SFT) begin
      step();
      if (s_pack() !== exp_pack(edges, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB)) model_bad++;
      if (!s_hs) hs_low++;
      if (!s_vs) vs_low++;
      if (s_blank) bl_high++;
      if (s_vbs) begin
        pulses++;
        if (s_x != 0 || s_y != coord_t'(SVV)) off_pulse++;
        if (edges - last_pulse != SFT) gap_bad++;
        last_pulse = edges;
`ifdef VGA_FRAME_CNT_EN
        check($sformatf("fc_pulse%0d", pulses + 1), 32'(s_fc), 32'((pulses + 1) % 4));
`endif
      end
    end
    check("frames_model_scan", 32'(model_bad), 32'd0);
    check("frames_hs_low", 32'(hs_low), 32'(4 * SVT * SHS));
    check("frames_vs_low", 32'(vs_low), 32'(4 * SVS * SHT));
    check("frames_blank_high", 32'(bl_high), 32'(4 * SHV * SVV));
    check("frames_vblank_pulses", 32'(pulses), 32'd4);
    check("frames_vblank_off_pos", 32'(off_pulse), 32'd0);
    check("frames_vblank_period", 32'(gap_bad), 32'd0);
`ifdef VGA_FRAME_CNT_EN
    check("dflt_fc_no_frame_yet", 32'(d_fc), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
